// File: rtl/dmem_lsu.sv
// Load/store unit between the RV32I result stage and a multi-cycle data memory.
// Runs one valid/ready request plus response per access and stalls the core until it retires.
module dmem_lsu #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_rd,
  input  logic        core_wr,
  input  logic [2:0]  core_funct3,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  output logic        core_done,
  output logic [31:0] core_rdata,
  output logic        core_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_be,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          addr_q, addr_d;
  logic [1:0]           off_q, off_d;
  logic [2:0]           f3_q, f3_d;
  logic                 we_q, we_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 access;
  logic                 misaligned;
  logic                 f3_ok;
  logic                 legal;
  logic [31:0]          st_wdata;
  logic [3:0]           st_be;
  logic [31:0]          lane_word;
  logic [31:0]          load_data;
  logic [TIMEOUT_W-1:0] cnt_inc;

  assign access = core_rd | core_wr;

  // Legality of the access presented in IDLE: alignment, funct3 and op exclusivity.
  always_comb begin
    misaligned = 1'b0;
    case (core_funct3[1:0])
      2'b01:   misaligned = core_addr[0];
      2'b10:   misaligned = |core_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    f3_ok = 1'b0;
    if (core_rd) begin
      f3_ok = (core_funct3 == 3'b000) || (core_funct3 == 3'b001) || (core_funct3 == 3'b010) ||
              (core_funct3 == 3'b100) || (core_funct3 == 3'b101);
    end else begin
      f3_ok = (core_funct3 == 3'b000) || (core_funct3 == 3'b001) || (core_funct3 == 3'b010);
    end
    legal = !(core_rd && core_wr) && f3_ok && !misaligned;
  end

  always_comb begin
    st_wdata = core_wdata;
    st_be    = 4'b1111;
    case (core_funct3[1:0])
      2'b00: begin
        st_wdata = {4{core_wdata[7:0]}};
        st_be    = 4'b0001 << core_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{core_wdata[15:0]}};
        st_be    = 4'b0011 << core_addr[1:0];
      end
      default: begin
        st_wdata = core_wdata;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend per funct3.
  always_comb begin
    lane_word = mem_rsp_data >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_data = {24'd0, lane_word[7:0]};
      3'b101:  load_data = {16'd0, lane_word[15:0]};
      default: load_data = mem_rsp_data;
    endcase
  end

  assign cnt_inc = cnt_q + TIMEOUT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    off_d   = off_q;
    f3_d    = f3_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (legal) begin
            state_d = REQ;
            addr_d  = {core_addr[31:2], 2'b00};
            off_d   = core_addr[1:0];
            f3_d    = core_funct3;
            we_d    = core_wr;
            wdata_d = core_wr ? st_wdata : 32'd0;
            be_d    = core_wr ? st_be : 4'b0000;
            err_d   = 1'b0;
            rdata_d = 32'd0;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = RSP;
          cnt_d   = '0;
        end
      end
      RSP: begin
        if (mem_rsp_valid) begin
          state_d = DONE;
          err_d   = mem_rsp_err;
          rdata_d = (mem_rsp_err || we_q) ? 32'd0 : load_data;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_W'(TIMEOUT)) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'd0;
      off_q   <= 2'd0;
      f3_q    <= 3'd0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request fields are gated to REQ so the bus is quiet outside a handshake.
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_we    = mem_req_valid & we_q;
  assign mem_req_addr  = mem_req_valid ? addr_q : 32'd0;
  assign mem_req_wdata = mem_req_valid ? wdata_q : 32'd0;
  assign mem_req_be    = mem_req_valid ? be_q : 4'd0;

  assign core_stall = access & (state_q != DONE);
  assign core_done  = (state_q == DONE);
  assign core_err   = core_done & err_q;
  assign core_rdata = core_done ? rdata_q : 32'd0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: an inline memory model answers requests and
// a scoreboard queue holds the expected retire result of each access.
module tb_dmem_lsu;

  logic        clk;
  logic        reset_n;
  logic        core_rd;
  logic        core_wr;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_stall;
  logic        core_done;
  logic [31:0] core_rdata;
  logic        core_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  dmem_lsu #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .core_rd       (core_rd),
    .core_wr       (core_wr),
    .core_funct3   (core_funct3),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_stall    (core_stall),
    .core_done     (core_done),
    .core_rdata    (core_rdata),
    .core_err      (core_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_be    (mem_req_be),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one access from a negedge, plays the memory cycle by cycle and
  // checks request fields every REQ cycle and the retire result against the queue.
  task automatic run_access(input string name, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ready_wait,
                            input logic rsp_en, input logic [31:0] rsp_data,
                            input logic rsp_err, input logic exp_req,
                            input logic [31:0] exp_addr, input logic chk_wdata,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                            input logic exp_we, input logic exp_err,
                            input logic [31:0] exp_rdata, input int exp_stalls);
    exp_t e;
    exp_t got;
    int   stalls;
    int   wait_left;
    logic rsp_next;
    logic hs;
    logic got_done;
    e.err    = exp_err;
    e.rdata  = exp_rdata;
    e.stalls = exp_stalls;
    exp_q.push_back(e);
    core_rd     = rd;
    core_wr     = wr;
    core_funct3 = f3;
    core_addr   = addr;
    core_wdata  = wdata;
    stalls      = 0;
    wait_left   = ready_wait;
    rsp_next    = 1'b0;
    got_done    = 1'b0;
    for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
      mem_req_ready = (wait_left == 0);
      mem_rsp_valid = rsp_next & rsp_en;
      mem_rsp_data  = rsp_data;
      mem_rsp_err   = rsp_err;
      #1;
      hs = 1'b0;
      if (core_stall) stalls++;
      if (mem_req_valid) begin
        checks++;
        if (!exp_req) begin
          errors++;
          $display("[TB] FAIL %s unexpected_req: valid=%0b required=0", name, mem_req_valid);
        end else if (mem_req_addr !== exp_addr || mem_req_be !== exp_be || mem_req_we !== exp_we ||
                     (chk_wdata && mem_req_wdata !== exp_wdata)) begin
          errors++;
          $display("[TB] FAIL %s req_fields: addr=%h be=%b we=%b wdata=%h required addr=%h be=%b we=%b wdata=%h",
                   name, mem_req_addr, mem_req_be, mem_req_we, mem_req_wdata,
                   exp_addr, exp_be, exp_we, exp_wdata);
        end
        if (wait_left > 0) wait_left--;
        else hs = 1'b1;
      end
      if (core_done) begin
        got_done = 1'b1;
        checks++;
        if (core_stall !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s stall_in_done: stall=%b required=0", name, core_stall);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL %s scoreboard: queue_size=0 required>=1", name);
        end else begin
          got = exp_q.pop_front();
          checks += 3;
          if (core_err !== got.err) begin
            errors++;
            $display("[TB] FAIL %s err: got=%b required=%b", name, core_err, got.err);
          end
          if (core_rdata !== got.rdata) begin
            errors++;
            $display("[TB] FAIL %s rdata: got=%h required=%h", name, core_rdata, got.rdata);
          end
          if (stalls != got.stalls) begin
            errors++;
            $display("[TB] FAIL %s stall_cycles: got=%0d required=%0d", name, stalls, got.stalls);
          end
        end
      end
      @(posedge clk);
      rsp_next = hs;
      @(negedge clk);
    end
    if (!got_done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s done_timeout: done=0 required=1 within 40 cycles", name);
      exp_q.delete();
    end
    core_rd       = 1'b0;
    core_wr       = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n       = 1'b1;
    core_rd       = 1'b0;
    core_wr       = 1'b0;
    core_funct3   = 3'd0;
    core_addr     = 32'd0;
    core_wdata    = 32'd0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'd0;
    mem_rsp_err   = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be} !== 70'd0) begin
      errors++;
      $display("[TB] FAIL reset_mem: valid=%b we=%b addr=%h wdata=%h be=%b required all 0",
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be);
    end
    checks++;
    if ({core_done, core_err, core_rdata, core_stall} !== 35'd0) begin
      errors++;
      $display("[TB] FAIL reset_core: done=%b err=%b rdata=%h stall=%b required all 0",
               core_done, core_err, core_rdata, core_stall);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loads();
    run_access("lw_basic", 1, 0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 0,
               1, 32'h100, 0, 32'h0, 4'b0000, 0, 0, 32'hDEADBEEF, 3);
    run_access("lb_sign", 1, 0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80112233, 0,
               1, 32'h100, 0, 32'h0, 4'b0000, 0, 0, 32'hFFFFFF80, 3);
    run_access("lbu_zero", 1, 0, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80112233, 0,
               1, 32'h100, 0, 32'h0, 4'b0000, 0, 0, 32'h00000080, 3);
    run_access("lh_sign", 1, 0, 3'b001, 32'h102, 32'h0, 0, 1, 32'h80010000, 0,
               1, 32'h100, 0, 32'h0, 4'b0000, 0, 0, 32'hFFFF8001, 3);
    run_access("lhu_zero", 1, 0, 3'b101, 32'h102, 32'h0, 0, 1, 32'h80010000, 0,
               1, 32'h100, 0, 32'h0, 4'b0000, 0, 0, 32'h00008001, 3);
  endtask

  task automatic test_stores();
    run_access("sh_upper", 0, 1, 3'b001, 32'h202, 32'h0000ABCD, 0, 1, 32'h0, 0,
               1, 32'h200, 1, 32'hABCDABCD, 4'b1100, 1, 0, 32'h0, 3);
    run_access("sb_lane1", 0, 1, 3'b000, 32'h101, 32'h000000A5, 0, 1, 32'h0, 0,
               1, 32'h100, 1, 32'hA5A5A5A5, 4'b0010, 1, 0, 32'h0, 3);
    run_access("sw_full", 0, 1, 3'b010, 32'h10, 32'h11223344, 0, 1, 32'h0, 0,
               1, 32'h10, 1, 32'h11223344, 4'b1111, 1, 0, 32'h0, 3);
  endtask

  task automatic test_illegal();
    run_access("lw_misaligned", 1, 0, 3'b010, 32'h101, 32'h0, 0, 1, 32'h0, 0,
               0, 32'h0, 0, 32'h0, 4'b0000, 0, 1, 32'h0, 1);
    run_access("sh_misaligned", 0, 1, 3'b001, 32'h3, 32'h1234, 0, 1, 32'h0, 0,
               0, 32'h0, 0, 32'h0, 4'b0000, 0, 1, 32'h0, 1);
    run_access("load_bad_f3", 1, 0, 3'b011, 32'h100, 32'h0, 0, 1, 32'h0, 0,
               0, 32'h0, 0, 32'h0, 4'b0000, 0, 1, 32'h0, 1);
    run_access("store_bad_f3", 0, 1, 3'b100, 32'h100, 32'h0, 0, 1, 32'h0, 0,
               0, 32'h0, 0, 32'h0, 4'b0000, 0, 1, 32'h0, 1);
    run_access("rd_and_wr", 1, 1, 3'b010, 32'h100, 32'h0, 0, 1, 32'h0, 0,
               0, 32'h0, 0, 32'h0, 4'b0000, 0, 1, 32'h0, 1);
  endtask

  task automatic test_backpressure();
    run_access("lw_ready_late", 1, 0, 3'b010, 32'h104, 32'h0, 5, 1, 32'h12345678, 0,
               1, 32'h104, 0, 32'h0, 4'b0000, 0, 0, 32'h12345678, 8);
    run_access("lw_bus_err", 1, 0, 3'b010, 32'h108, 32'h0, 0, 1, 32'hFFFFFFFF, 1,
               1, 32'h108, 0, 32'h0, 4'b0000, 0, 1, 32'h0, 3);
    run_access("lw_timeout", 1, 0, 3'b010, 32'h10C, 32'h0, 0, 0, 32'h0, 0,
               1, 32'h10C, 0, 32'h0, 4'b0000, 0, 1, 32'h0, 6);
  endtask

  task automatic test_reset_mid();
    core_rd       = 1'b1;
    core_funct3   = 3'b010;
    core_addr     = 32'h110;
    mem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (core_stall !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_rsp_state: stall=%b valid=%b required stall=1 valid=0",
               core_stall, mem_req_valid);
    end
    core_rd       = 1'b0;
    mem_req_ready = 1'b0;
    reset_n       = 1'b0;
    #1;
    checks++;
    if (core_done !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: done=%b valid=%b required 0 0", core_done, mem_req_valid);
    end
    @(negedge clk);
    reset_n       = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h55;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (core_done !== 1'b0 || core_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL late_rsp_ignored: done=%b err=%b required 0 0", core_done, core_err);
      end
      @(negedge clk);
    end
    run_access("lw_after_reset", 1, 0, 3'b010, 32'h110, 32'h0, 0, 1, 32'hCAFEF00D, 0,
               1, 32'h110, 0, 32'h0, 4'b0000, 0, 0, 32'hCAFEF00D, 3);
  endtask

  task automatic test_back_to_back();
    run_access("b2b_sw", 0, 1, 3'b010, 32'h300, 32'hA1B2C3D4, 0, 1, 32'h0, 0,
               1, 32'h300, 1, 32'hA1B2C3D4, 4'b1111, 1, 0, 32'h0, 3);
    run_access("b2b_lbu", 1, 0, 3'b100, 32'h301, 32'h0, 0, 1, 32'hA1B2C3D4, 0,
               1, 32'h300, 0, 32'h0, 4'b0000, 0, 0, 32'h000000C3, 3);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_loads();
    test_stores();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
